// File: rtl/hwpe_stream_addressgen_sequencer_pkg.sv
// Shared types for the addressgen job sequencer:
// job descriptor, addressgen flags and sequencer states.
package hwpe_stream_addressgen_sequencer_pkg;

    localparam int unsigned JOBS_CNT_WIDTH = 16;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] trans_size;
        logic [15:0] line_stride;
        logic [15:0] line_length;
        logic [15:0] feat_stride;
        logic [15:0] feat_length;
        logic [15:0] feat_roll;
        logic [31:0] loop_outer;
        logic [7:0]  realign_type;
        logic [7:0]  step;
    } ctrl_addressgen_t;

    typedef struct packed {
        logic        enable;
        logic        last;
        logic        first;
        logic        last_packet;
        logic [15:0] line_length;
    } ctrl_realign_t;

    typedef struct packed {
        logic          in_progress;
        ctrl_realign_t realign_flags;
    } flags_addressgen_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SETTLE,
        SEQ_RUN,
        SEQ_DONE
    } addressgen_seq_state_t;

endpackage

// File: rtl/hwpe_stream_addressgen_job_fifo.sv
// Small descriptor FIFO with flush; full/empty come
// straight from the occupancy register.
module hwpe_stream_addressgen_job_fifo
    import hwpe_stream_addressgen_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type data_t = ctrl_addressgen_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  flush_i,
    input  logic  push_i,
    input  data_t data_i,
    input  logic  pop_i,
    output data_t data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    data_t         mem_q [DEPTH];
    data_t         mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer/occupancy update; flush drops every entry.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = data_i;
                wr_d        = next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_d = next_ptr(rd_q);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/hwpe_stream_addressgen_sequencer.sv
// Job-level controller: queues addressgen jobs, loads
// them one at a time and counts beats to completion.
module hwpe_stream_addressgen_sequencer
    import hwpe_stream_addressgen_sequencer_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  ctrl_addressgen_t  job_i,
    output ctrl_addressgen_t  ag_ctrl_o,
    output logic              ag_clear_o,
    output logic              ag_enable_o,
    input  flags_addressgen_t ag_flags_i,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       jobs_done_o
);

    addressgen_seq_state_t state_q, state_d;
    ctrl_addressgen_t      active_q, active_d;
    logic [CNT_WIDTH-1:0]  target_q, target_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [JOBS_CNT_WIDTH-1:0] jobs_done_q, jobs_done_d;

    ctrl_addressgen_t      head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  handshake;
    logic [CNT_WIDTH-1:0]  settle_target;
    flags_addressgen_t     unused_flags;

    assign unused_flags  = ag_flags_i;
    assign job_ready_o   = ~full & ~rst_i;
    assign push          = job_valid_i & job_ready_o & ~clear_i;
    assign handshake     = addr_valid_o & addr_ready_i;
    assign settle_target = CNT_WIDTH'(active_q.trans_size)
                         + CNT_WIDTH'(ag_flags_i.realign_flags.enable);

    hwpe_stream_addressgen_job_fifo #(
        .DEPTH  ( QUEUE_DEPTH       ),
        .data_t ( ctrl_addressgen_t )
    ) i_job_fifo (
        .clk_i   ( clk_i   ),
        .rst_i   ( rst_i   ),
        .flush_i ( clear_i ),
        .push_i  ( push    ),
        .data_i  ( job_i   ),
        .pop_i   ( pop     ),
        .data_o  ( head    ),
        .full_o  ( full    ),
        .empty_o ( empty   )
    );

    // State and job datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SEQ_IDLE;
            active_q    <= '0;
            target_q    <= '0;
            count_q     <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            target_q    <= target_d;
            count_q     <= count_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    // Next state: a soft clear aborts everything but
    // the completed-job count.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        target_d    = target_q;
        count_d     = count_q;
        jobs_done_d = jobs_done_q;
        pop         = 1'b0;
        if (clear_i) begin
            state_d = SEQ_IDLE;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        active_d = head;
                        state_d  = SEQ_LOAD;
                    end
                end
                SEQ_LOAD: state_d = SEQ_SETTLE;
                SEQ_SETTLE: begin
                    target_d = settle_target;
                    count_d  = '0;
                    state_d  = (settle_target == '0) ? SEQ_DONE
                                                     : SEQ_RUN;
                end
                SEQ_RUN: begin
                    if (handshake) begin
                        count_d = count_q + CNT_WIDTH'(1);
                        if (count_q == target_q - CNT_WIDTH'(1)) begin
                            state_d = SEQ_DONE;
                        end
                    end
                end
                SEQ_DONE: begin
                    jobs_done_d = jobs_done_q + JOBS_CNT_WIDTH'(1);
                    if (!empty) begin
                        pop      = 1'b1;
                        active_d = head;
                        state_d  = SEQ_LOAD;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        ag_ctrl_o    = active_q;
        ag_clear_o   = rst_i | clear_i | (state_q == SEQ_LOAD);
        addr_valid_o = (state_q == SEQ_RUN);
        ag_enable_o  = addr_valid_o & addr_ready_i;
        done_o       = (state_q == SEQ_DONE);
        busy_o       = (state_q != SEQ_IDLE) | ~empty;
        jobs_done_o  = jobs_done_q;
    end

`ifndef SYNTHESIS
    // The generator must still be producing while we enable it.
    assert property (@(posedge clk_i) disable iff (rst_i)
        ag_enable_o |-> ag_flags_i.in_progress)
    else $error("enable issued while addressgen idle");
`endif

endmodule

// File: tb/tb_hwpe_stream_addressgen_sequencer.sv
// Directed bench for the addressgen job sequencer:
// cycle vector table plus a few bounded job runs.
module tb_hwpe_stream_addressgen_sequencer;
    import hwpe_stream_addressgen_sequencer_pkg::*;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              jv;
    logic              jr;
    ctrl_addressgen_t  job;
    ctrl_addressgen_t  ag_ctrl;
    logic              ag_clear;
    logic              ag_en;
    flags_addressgen_t flags;
    logic              av;
    logic              rdy;
    logic              busy;
    logic              done;
    logic [15:0]       jd;

    int nvec = 0;
    int nbad = 0;

    hwpe_stream_addressgen_sequencer #(
        .QUEUE_DEPTH ( 2  ),
        .CNT_WIDTH   ( 32 )
    ) dut (
        .clk_i        ( clk      ),
        .rst_i        ( rst      ),
        .clear_i      ( clr      ),
        .job_valid_i  ( jv       ),
        .job_ready_o  ( jr       ),
        .job_i        ( job      ),
        .ag_ctrl_o    ( ag_ctrl  ),
        .ag_clear_o   ( ag_clear ),
        .ag_enable_o  ( ag_en    ),
        .ag_flags_i   ( flags    ),
        .addr_valid_o ( av       ),
        .addr_ready_i ( rdy      ),
        .busy_o       ( busy     ),
        .done_o       ( done     ),
        .jobs_done_o  ( jd       )
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in addressgen: misaligned base sets realign.
    always_comb begin
        flags = '0;
        flags.in_progress = 1'b1;
        flags.realign_flags.enable = (ag_ctrl.base_addr[1:0] != 2'b00);
    end

    // in: {rst,clr,jv,rdy}; exp: {jr,ag_clear,en,av,busy,done}
    typedef struct {
        int          n;
        logic [3:0]  in;
        logic [31:0] base;
        logic [31:0] ts;
        logic [5:0]  exp;
        logic [15:0] jd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic [3:0] in,
                       input logic [31:0] base, input logic [31:0] ts,
                       input logic [5:0] exp, input logic [15:0] jdv);
        vec_t v;
        v.n = n; v.in = in; v.base = base;
        v.ts = ts; v.exp = exp; v.jd = jdv;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] in,
                         input logic [31:0] base, input logic [31:0] ts);
        {rst, clr, jv, rdy} = in;
        job = '0;
        job.base_addr  = base;
        job.trans_size = ts;
    endtask

    task automatic check(input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int exp_jd = 0;

    task automatic run_job(input logic [31:0] base, input logic [31:0] ts,
                           input int exp_beats);
        int beats;
        bit seen;
        beats = 0;
        seen = 1'b0;
        @(negedge clk);
        drive(4'b0010, base, ts);
        #1;
        check("job_ready", 64'(jr), 64'd1);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            jv  = 1'b0;
            rdy = i[0];
            #1;
            if (ag_en) beats++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("beats", 64'(beats), 64'(exp_beats));
        exp_jd++;
        @(negedge clk);
        rdy = 1'b0;
        #1;
        check("jobs_done", 64'(jd), 64'(exp_jd));
        check("busy_idle", 64'(busy), 64'd0);
        check("ctrl_hold", {ag_ctrl.base_addr, ag_ctrl.trans_size},
              {base, ts});
    endtask

    localparam logic [31:0] A = 32'h1000;
    localparam logic [31:0] M = 32'h1002;

    initial begin
        drive(4'b1000, 0, 0);
        @(posedge clk);

        // reset
        add(1, 4'b1000, 0, 0, 6'b010000, 0);
        // aligned 8-beat job
        add(1, 4'b0010, A, 8, 6'b100000, 0);
        add(1, 4'b0000, A, 8, 6'b100010, 0);
        add(1, 4'b0000, A, 8, 6'b110010, 0);
        add(1, 4'b0000, A, 8, 6'b100010, 0);
        add(8, 4'b0001, A, 8, 6'b101110, 0);
        add(1, 4'b0001, A, 8, 6'b100011, 0);
        add(1, 4'b0001, A, 8, 6'b100000, 1);
        // misaligned: 9 beats
        add(1, 4'b0010, M, 8, 6'b100000, 1);
        add(1, 4'b0000, M, 8, 6'b100010, 1);
        add(1, 4'b0000, M, 8, 6'b110010, 1);
        add(1, 4'b0000, M, 8, 6'b100010, 1);
        add(9, 4'b0001, M, 8, 6'b101110, 1);
        add(1, 4'b0000, M, 8, 6'b100011, 1);
        add(1, 4'b0000, M, 8, 6'b100000, 2);
        // 4 beats, ready toggling
        add(1, 4'b0010, A, 4, 6'b100000, 2);
        add(1, 4'b0000, A, 4, 6'b100010, 2);
        add(1, 4'b0000, A, 4, 6'b110010, 2);
        add(1, 4'b0000, A, 4, 6'b100010, 2);
        for (int k = 0; k < 3; k++) begin
            add(1, 4'b0001, A, 4, 6'b101110, 2);
            add(1, 4'b0000, A, 4, 6'b100110, 2);
        end
        add(1, 4'b0001, A, 4, 6'b101110, 2);
        add(1, 4'b0000, A, 4, 6'b100011, 2);
        add(1, 4'b0000, A, 4, 6'b100000, 3);
        // three jobs back to back, queue fills
        add(1, 4'b0010, A, 2, 6'b100000, 3);
        add(1, 4'b0010, A, 2, 6'b100010, 3);
        add(1, 4'b0010, A, 2, 6'b110010, 3);
        add(1, 4'b0000, A, 2, 6'b000010, 3);
        add(2, 4'b0001, A, 2, 6'b001110, 3);
        add(1, 4'b0001, A, 2, 6'b000011, 3);
        add(1, 4'b0000, A, 2, 6'b110010, 4);
        add(1, 4'b0000, A, 2, 6'b100010, 4);
        add(2, 4'b0001, A, 2, 6'b101110, 4);
        add(1, 4'b0001, A, 2, 6'b100011, 4);
        add(1, 4'b0000, A, 2, 6'b110010, 5);
        add(1, 4'b0000, A, 2, 6'b100010, 5);
        add(2, 4'b0001, A, 2, 6'b101110, 5);
        add(1, 4'b0001, A, 2, 6'b100011, 5);
        add(1, 4'b0000, A, 2, 6'b100000, 6);
        // clear after 3 of 8 beats, one job queued
        add(1, 4'b0010, A, 8, 6'b100000, 6);
        add(1, 4'b0010, A, 8, 6'b100010, 6);
        add(1, 4'b0000, A, 8, 6'b110010, 6);
        add(1, 4'b0000, A, 8, 6'b100010, 6);
        add(3, 4'b0001, A, 8, 6'b101110, 6);
        add(1, 4'b0110, A, 8, 6'b110110, 6);
        add(2, 4'b0000, A, 8, 6'b100000, 6);
        // zero-size job
        add(1, 4'b0010, A, 0, 6'b100000, 6);
        add(1, 4'b0000, A, 0, 6'b100010, 6);
        add(1, 4'b0000, A, 0, 6'b110010, 6);
        add(1, 4'b0001, A, 0, 6'b100010, 6);
        add(1, 4'b0001, A, 0, 6'b100011, 6);
        add(1, 4'b0000, A, 0, 6'b100000, 7);
        // reset mid-RUN
        add(1, 4'b0010, A, 8, 6'b100000, 7);
        add(1, 4'b0000, A, 8, 6'b100010, 7);
        add(1, 4'b0000, A, 8, 6'b110010, 7);
        add(1, 4'b0000, A, 8, 6'b100010, 7);
        add(2, 4'b0001, A, 8, 6'b101110, 7);
        add(1, 4'b1001, A, 8, 6'b011110, 7);
        add(1, 4'b1001, A, 8, 6'b010000, 0);
        add(1, 4'b0000, A, 8, 6'b100000, 0);

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].n; r++) begin
                @(negedge clk);
                drive(vecs[v].in, vecs[v].base, vecs[v].ts);
                #1;
                nvec++;
                if ({jr, ag_clear, ag_en, av, busy, done} !== vecs[v].exp
                    || jd !== vecs[v].jd) begin
                    nbad++;
                    $display("FAIL vec%0d.%0d: outs=%b jd=%0d expected outs=%b jd=%0d",
                             v, r, {jr, ag_clear, ag_en, av, busy, done},
                             jd, vecs[v].exp, vecs[v].jd);
                end
            end
        end

        check("ctrl_after_reset", 64'(ag_ctrl), 64'd0);
        exp_jd = 0;
        run_job(32'h2000, 5, 5);
        run_job(32'h3001, 0, 1);
        run_job(32'h3003, 3, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
